main_fsm: RTL and testbench
===========================

# main_fsm

Multicycle control state machine for the RV32I multicycle datapath. It sits directly upstream of the ALU decoder: it decodes the 7-bit opcode held in the instruction register and sequences the instruction through fetch, decode, execute, memory and write-back. Each cycle it drives the 2-bit ALUOp that the ALU decoder consumes, plus every datapath mux select and write enable.

## Interface
- No parameters. All encodings come from the shared defines.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- op  in  7  opcode, taken from instruction register bits [6:0]; only meaningful from DECODE onward
- zero  in  1  ALU zero flag, same cycle
- stall  in  1  hold current state and suppress all write enables
- PCWrite  out  1  PC register enable; equals (PCUpdate | (Branch & zero)) & ~stall
- AdrSrc  out  1  memory address select: 0 = PC, 1 = Result
- MemWrite  out  1  data memory write enable
- IRWrite  out  1  instruction register and OldPC enable
- ResultSrc  out  2  result select: 00 = ALUOut, 01 = Data, 10 = ALUResult
- ALUSrcA  out  2  ALU operand A select: 00 = PC, 01 = OldPC, 10 = RD1
- ALUSrcB  out  2  ALU operand B select: 00 = RD2, 01 = ImmExt, 10 = constant 4
- ALUOp  out  2  to the ALU decoder: 00 = add, 01 = sub, 10 = decode funct3/funct7
- ImmSrc  out  2  immediate format, decoded from op combinationally: I/load 00, S 01, B 10, J 11, anything else 00
- RegWrite  out  1  register file write enable
- illegal_op  out  1  high in DECODE when op is unsupported
- fsm_state  out  4  current state encoding, for debug and verification

## Operation
- Moore FSM. Every output except PCWrite and ImmSrc is a function of the state only. Any output not listed for a state is 0.
- Supported opcodes:
  - 0000011 lw
  - 0100011 sw
  - 0110011 R-type
  - 0010011 I-type ALU
  - 1100011 beq
  - 1101111 jal
- States, their actions, and next state:
  - IDLE: all outputs 0. Next: FETCH.
  - FETCH: IRWrite=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10, PCUpdate=1. Next: DECODE.
  - DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (computes the branch target). Next by op:
    - lw or sw → MEMADR
    - R-type → EXECR
    - I-type ALU → EXECI
    - beq → BEQ
    - jal → JAL
    - any other op → illegal_op=1, then FETCH (the instruction is skipped)
  - MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. Next: MEMREAD for lw, MEMWRITE for sw.
  - MEMREAD: ResultSrc=00, AdrSrc=1. Next: MEMWB.
  - MEMWB: ResultSrc=01, RegWrite=1. Next: FETCH.
  - MEMWRITE: ResultSrc=00, AdrSrc=1, MemWrite=1. Next: FETCH.
  - EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10. Next: ALUWB.
  - EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10. Next: ALUWB.
  - ALUWB: ResultSrc=00, RegWrite=1. Next: FETCH.
  - BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1. Next: FETCH.
  - JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1. Next: ALUWB.
- stall=1 behaviour:
  - the state register holds;
  - PCWrite, IRWrite, RegWrite and MemWrite are forced to 0;
  - select outputs, ALUOp and illegal_op keep their state values.
- Undefined state encodings recover to FETCH on the next edge.

## Timing
- Reset: rst_n low forces IDLE asynchronously. All outputs are 0 while reset is asserted, except ImmSrc, which follows op. fsm_state reads IDLE.
- The first rising edge after rst_n deasserts moves to FETCH. Deasserting reset mid-instruction always restarts at IDLE, then FETCH.
- Cycles per instruction, FETCH to FETCH, with no stall:
  - lw: 5
  - sw, R-type, I-type, jal: 4
  - beq: 3
  - illegal op: 2
- Each stall cycle adds exactly one cycle in the stalled state.
- The branch is taken on the single BEQ cycle: PCWrite = zero in that cycle.
- op is sampled only in DECODE and MEMADR. Its value in any other state has no effect on the state transitions.

## Structure
- Shared defines header holds:
  - state encodings (4-bit);
  - opcode constants;
  - ALUOp, ALUSrcA, ALUSrcB, ResultSrc and ImmSrc encodings.
- The ALU decoder uses the same ALUOp constants from that header.
- One sub-module: imm_src_decoder, combinational, op to ImmSrc. It is reused by the single-cycle main decoder.
- The top level contains the state register, next-state logic, output decode and PCWrite gating.

## Test plan
- Reset and lw: hold rst_n=0 for 3 cycles, then release with op=0000011.
  - During reset: all enables 0.
  - Visits IDLE, FETCH, DECODE, MEMADR, MEMREAD, MEMWB, FETCH.
  - RegWrite=1 only in MEMWB; ResultSrc=01 in MEMWB.
- sw and R-type:
  - op=0100011: MemWrite=1 for exactly one cycle (MEMWRITE), with AdrSrc=1; RegWrite never asserts.
  - op=0110011: ALUOp=10 in EXECR, then RegWrite=1 in ALUWB; 4 cycles total.
- beq:
  - op=1100011 with zero=1 in BEQ: PCWrite=1 and ALUOp=01 in that cycle.
  - Repeat with zero=0: PCWrite=0 in BEQ; 3 cycles in both cases.
- jal:
  - op=1101111: PCWrite=1 in JAL with ALUSrcA=01 and ALUSrcB=10.
  - Then ALUWB with RegWrite=1; ImmSrc=11 throughout.
- Stall and illegal op:
  - stall=1 for 2 cycles during MEMWRITE: state holds, MemWrite=0 on both stalled cycles, then MemWrite=1 for one cycle after release.
  - op=1111111: illegal_op=1 in DECODE, then FETCH; no write enable asserts outside FETCH.
- Async reset mid-instruction: drop rst_n between clock edges while in MEMREAD.
  - fsm_state becomes IDLE immediately, without waiting for a clock edge.
  - All enables go to 0; after release the FSM restarts at FETCH.

Source files
------------

// File: rtl/main_fsm_pkg.sv
// main_fsm_pkg
// Shared encodings for the RV32I multicycle control path: FSM state codes,
// opcode constants and the ALUOp / mux-select / immediate-format encodings.
// The ALU decoder and the single-cycle main decoder use the same constants.
// Also holds the per-state control bundle and the function that maps a
// state to its Moore outputs.
package main_fsm_pkg;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEMADR   = 4'd3,
        S_MEMREAD  = 4'd4,
        S_MEMWB    = 4'd5,
        S_MEMWRITE = 4'd6,
        S_EXECR    = 4'd7,
        S_EXECI    = 4'd8,
        S_ALUWB    = 4'd9,
        S_BEQ      = 4'd10,
        S_JAL      = 4'd11
    } state_t;

    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    // Everything the FSM drives that depends on the state alone.
    // pcUpdate and branch are internal; they are combined with zero and
    // stall at the top level to form PCWrite.
    typedef struct packed {
        logic       pcUpdate;
        logic       branch;
        logic       adrSrc;
        logic       memWrite;
        logic       irWrite;
        logic [1:0] resultSrc;
        logic [1:0] aluSrcA;
        logic [1:0] aluSrcB;
        logic [1:0] aluOp;
        logic       regWrite;
    } ctrl_t;

    // Moore output table; unlisted fields stay 0, and unknown states
    // produce an all-zero bundle.
    function automatic ctrl_t stateControls(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.irWrite   = 1'b1;
                c.aluSrcA   = SRCA_PC;
                c.aluSrcB   = SRCB_FOUR;
                c.aluOp     = ALUOP_ADD;
                c.resultSrc = RES_ALURESULT;
                c.pcUpdate  = 1'b1;
            end
            S_DECODE: begin
                c.aluSrcA = SRCA_OLDPC;
                c.aluSrcB = SRCB_IMM;
                c.aluOp   = ALUOP_ADD;
            end
            S_MEMADR, S_EXECI: begin
                c.aluSrcA = SRCA_RD1;
                c.aluSrcB = SRCB_IMM;
                c.aluOp   = (s == S_EXECI) ? ALUOP_FUNCT : ALUOP_ADD;
            end
            S_MEMREAD: begin
                c.resultSrc = RES_ALUOUT;
                c.adrSrc    = 1'b1;
            end
            S_MEMWB: begin
                c.resultSrc = RES_DATA;
                c.regWrite  = 1'b1;
            end
            S_MEMWRITE: begin
                c.resultSrc = RES_ALUOUT;
                c.adrSrc    = 1'b1;
                c.memWrite  = 1'b1;
            end
            S_EXECR: begin
                c.aluSrcA = SRCA_RD1;
                c.aluSrcB = SRCB_RD2;
                c.aluOp   = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                c.resultSrc = RES_ALUOUT;
                c.regWrite  = 1'b1;
            end
            S_BEQ: begin
                c.aluSrcA   = SRCA_RD1;
                c.aluSrcB   = SRCB_RD2;
                c.aluOp     = ALUOP_SUB;
                c.resultSrc = RES_ALUOUT;
                c.branch    = 1'b1;
            end
            S_JAL: begin
                c.aluSrcA   = SRCA_OLDPC;
                c.aluSrcB   = SRCB_FOUR;
                c.aluOp     = ALUOP_ADD;
                c.resultSrc = RES_ALUOUT;
                c.pcUpdate  = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    function automatic logic isSupportedOp(input logic [6:0] op);
        return (op == OP_LW) || (op == OP_SW) || (op == OP_RTYPE) ||
               (op == OP_ITYPE) || (op == OP_BEQ) || (op == OP_JAL);
    endfunction

endpackage

// File: rtl/main_fsm_imm_src_decoder.sv
// imm_src_decoder
// Combinational opcode to immediate-format decode. Shared between the
// multicycle FSM and the single-cycle main decoder.
//   op_i      [6:0]  instruction opcode
//   immSrc_o  [1:0]  immediate format (I/load 00, S 01, B 10, J 11)
module imm_src_decoder
    import main_fsm_pkg::*;
(
    input  logic [6:0] op_i,
    output logic [1:0] immSrc_o
);

    // Loads, I-type ALU and all unknown opcodes share the I format.
    always_comb begin
        immSrc_o = IMM_I;
        case (op_i)
            OP_SW:   immSrc_o = IMM_S;
            OP_BEQ:  immSrc_o = IMM_B;
            OP_JAL:  immSrc_o = IMM_J;
            default: immSrc_o = IMM_I;
        endcase
    end

endmodule

// File: rtl/main_fsm.sv
// main_fsm
// Multicycle RV32I control FSM. Sequences each instruction through
// fetch, decode, execute, memory and write-back and drives the datapath
// selects, write enables and the ALUOp consumed by the ALU decoder.
//   clk, rst_n        clock, asynchronous active-low reset
//   op [6:0]          opcode from the instruction register
//   zero              ALU zero flag (same cycle)
//   stall             hold state and suppress all write enables
//   PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite   enables / address select
//   ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc     2-bit selects
//   illegal_op        unsupported opcode seen in DECODE
//   fsm_state [3:0]   current state encoding
module main_fsm (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic       zero,
    input  logic       stall,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] ImmSrc,
    output logic       RegWrite,
    output logic       illegal_op,
    output logic [3:0] fsm_state
);
    import main_fsm_pkg::*;

    state_t state_q;
    state_t state_d;
    ctrl_t  ctrl_q;

    // Next-state logic. op is only looked at in DECODE and MEMADR; a stall
    // freezes the current state. Unknown encodings fall back to FETCH.
    always_comb begin
        state_d = state_q;
        if (!stall) begin
            case (state_q)
                S_IDLE:     state_d = S_FETCH;
                S_FETCH:    state_d = S_DECODE;
                S_DECODE: begin
                    case (op)
                        OP_LW, OP_SW: state_d = S_MEMADR;
                        OP_RTYPE:     state_d = S_EXECR;
                        OP_ITYPE:     state_d = S_EXECI;
                        OP_BEQ:       state_d = S_BEQ;
                        OP_JAL:       state_d = S_JAL;
                        default:      state_d = S_FETCH;
                    endcase
                end
                S_MEMADR:   state_d = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
                S_MEMREAD:  state_d = S_MEMWB;
                S_MEMWB:    state_d = S_FETCH;
                S_MEMWRITE: state_d = S_FETCH;
                S_EXECR:    state_d = S_ALUWB;
                S_EXECI:    state_d = S_ALUWB;
                S_ALUWB:    state_d = S_FETCH;
                S_BEQ:      state_d = S_FETCH;
                S_JAL:      state_d = S_ALUWB;
                default:    state_d = S_FETCH;
            endcase
        end
    end

    // State register with the Moore outputs registered alongside it: the
    // control bundle is decoded from the next state, so it always matches
    // state_q and clears together with it on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ctrl_q  <= '0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= stateControls(state_d);
        end
    end

    imm_src_decoder u_immSrcDecoder (
        .op_i     (op),
        .immSrc_o (ImmSrc)
    );

    // Write enables are gated by stall; the selects keep their state values.
    assign PCWrite    = (ctrl_q.pcUpdate | (ctrl_q.branch & zero)) & ~stall;
    assign IRWrite    = ctrl_q.irWrite & ~stall;
    assign RegWrite   = ctrl_q.regWrite & ~stall;
    assign MemWrite   = ctrl_q.memWrite & ~stall;
    assign AdrSrc     = ctrl_q.adrSrc;
    assign ResultSrc  = ctrl_q.resultSrc;
    assign ALUSrcA    = ctrl_q.aluSrcA;
    assign ALUSrcB    = ctrl_q.aluSrcB;
    assign ALUOp      = ctrl_q.aluOp;
    assign illegal_op = (state_q == S_DECODE) & ~isSupportedOp(op);
    assign fsm_state  = state_q;

endmodule

// File: tb/tb_main_fsm.sv
// tb_main_fsm
// Self-checking bench for main_fsm. Each planned cycle (inputs plus the
// expected state and outputs) is pushed to a scoreboard queue; the driver
// pops one entry per cycle, applies its inputs and compares the DUT.
module tb_main_fsm;
    import main_fsm_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] op = OP_LW;
    logic       zero = 1'b0;
    logic       stall = 1'b0;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal_op;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc;
    logic [3:0] fsm_state;
    logic [15:0] dutOuts;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        rstN;
        logic [6:0]  op;
        logic        stall;
        logic        zero;
        logic [3:0]  state;
        logic [15:0] outs;
    } row_t;

    row_t scoreboard[$];

    main_fsm dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .op         (op),
        .zero       (zero),
        .stall      (stall),
        .PCWrite    (PCWrite),
        .AdrSrc     (AdrSrc),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ALUOp      (ALUOp),
        .ImmSrc     (ImmSrc),
        .RegWrite   (RegWrite),
        .illegal_op (illegal_op),
        .fsm_state  (fsm_state)
    );

    always #5 clk = ~clk;

    assign dutOuts = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA,
                      ALUSrcB, ALUOp, ImmSrc, RegWrite, illegal_op};

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Expected outputs written straight from the state action table.
    function automatic logic [15:0] specOutputs(input logic [3:0] st, input logic stallIn,
                                                input logic zeroIn, input logic [6:0] opIn);
        logic pcW, adr, memW, irW, regW, ill;
        logic [1:0] res, a, b, aop, imm;
        {pcW, adr, memW, irW, regW, ill} = '0;
        {res, a, b, aop} = '0;
        case (opIn)
            7'b0100011: imm = 2'b01;
            7'b1100011: imm = 2'b10;
            7'b1101111: imm = 2'b11;
            default:    imm = 2'b00;
        endcase
        case (st)
            S_FETCH:    begin irW = 1; b = 2'b10; res = 2'b10; pcW = 1; end
            S_DECODE:   begin
                a = 2'b01; b = 2'b01;
                ill = !(opIn inside {7'b0000011, 7'b0100011, 7'b0110011,
                                     7'b0010011, 7'b1100011, 7'b1101111});
            end
            S_MEMADR:   begin a = 2'b10; b = 2'b01; end
            S_MEMREAD:  begin adr = 1; end
            S_MEMWB:    begin res = 2'b01; regW = 1; end
            S_MEMWRITE: begin adr = 1; memW = 1; end
            S_EXECR:    begin a = 2'b10; aop = 2'b10; end
            S_EXECI:    begin a = 2'b10; b = 2'b01; aop = 2'b10; end
            S_ALUWB:    begin regW = 1; end
            S_BEQ:      begin a = 2'b10; aop = 2'b01; pcW = zeroIn; end
            S_JAL:      begin a = 2'b01; b = 2'b10; pcW = 1; end
            default:    ;
        endcase
        if (stallIn) begin
            pcW = 0; irW = 0; regW = 0; memW = 0;
        end
        return {pcW, adr, memW, irW, res, a, b, aop, imm, regW, ill};
    endfunction

    task automatic applyStimulus(input logic [6:0] opIn, input logic rstN, input logic stallIn,
                                 input logic zeroIn, input logic [3:0] st);
        row_t r;
        r.rstN  = rstN;
        r.op    = opIn;
        r.stall = stallIn;
        r.zero  = zeroIn;
        r.state = st;
        r.outs  = (rstN && st != S_IDLE) ? specOutputs(st, stallIn, zeroIn, opIn)
                                         : specOutputs(S_IDLE, 1'b0, 1'b0, opIn);
        scoreboard.push_back(r);
    endtask

    // One instruction, FETCH up to (not including) the next FETCH.
    // The row count per opcode is the expected cycles per instruction.
    task automatic applyInstr(input logic [6:0] opIn, input logic beqZero);
        logic z;
        z = 1'($urandom_range(0, 1));
        applyStimulus(opIn, 1, 0, z, S_FETCH);
        z = 1'($urandom_range(0, 1));
        applyStimulus(opIn, 1, 0, z, S_DECODE);
        case (opIn)
            OP_LW:    begin
                applyStimulus(opIn, 1, 0, z, S_MEMADR);
                applyStimulus(opIn, 1, 0, z, S_MEMREAD);
                applyStimulus(opIn, 1, 0, z, S_MEMWB);
            end
            OP_SW:    begin
                applyStimulus(opIn, 1, 0, z, S_MEMADR);
                applyStimulus(opIn, 1, 0, z, S_MEMWRITE);
            end
            OP_RTYPE: begin
                applyStimulus(opIn, 1, 0, z, S_EXECR);
                applyStimulus(opIn, 1, 0, z, S_ALUWB);
            end
            OP_ITYPE: begin
                applyStimulus(opIn, 1, 0, z, S_EXECI);
                applyStimulus(opIn, 1, 0, z, S_ALUWB);
            end
            OP_BEQ:   applyStimulus(opIn, 1, 0, beqZero, S_BEQ);
            OP_JAL:   begin
                applyStimulus(opIn, 1, 0, z, S_JAL);
                applyStimulus(opIn, 1, 0, z, S_ALUWB);
            end
            default:  ;
        endcase
    endtask

    // Drain the scoreboard: drive each row's inputs at the falling edge,
    // compare shortly after, then advance one clock.
    task automatic runQueue();
        row_t r;
        while (scoreboard.size() > 0) begin
            r = scoreboard.pop_front();
            rst_n = r.rstN;
            op    = r.op;
            stall = r.stall;
            zero  = r.zero;
            #1;
            checkOutput($sformatf("state op=%b exp=%0d", r.op, r.state),
                        32'(fsm_state), 32'(r.state));
            checkOutput($sformatf("outs op=%b state=%0d stall=%b zero=%b",
                                  r.op, r.state, r.stall, r.zero),
                        32'(dutOuts), 32'(r.outs));
            @(negedge clk);
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Stimulus plan: reset then lw, the other opcodes, beq both ways, jal,
    // a stalled sw, an illegal opcode, and an async reset mid-lw.
    initial begin
        @(negedge clk);
        repeat (3) applyStimulus(OP_LW, 0, 0, 0, S_IDLE);
        applyStimulus(OP_LW, 1, 0, 0, S_IDLE);
        applyInstr(OP_LW, 0);
        applyInstr(OP_SW, 0);
        applyInstr(OP_RTYPE, 0);
        applyInstr(OP_ITYPE, 0);
        applyInstr(OP_BEQ, 1);
        applyInstr(OP_BEQ, 0);
        applyInstr(OP_JAL, 0);

        applyStimulus(OP_SW, 1, 0, 1, S_FETCH);
        applyStimulus(OP_SW, 1, 0, 1, S_DECODE);
        applyStimulus(OP_SW, 1, 0, 0, S_MEMADR);
        applyStimulus(OP_SW, 1, 1, 1, S_MEMWRITE);
        applyStimulus(OP_SW, 1, 1, 0, S_MEMWRITE);
        applyStimulus(OP_SW, 1, 0, 1, S_MEMWRITE);

        applyInstr(7'b1111111, 0);
        applyStimulus(OP_LW, 1, 0, 1, S_FETCH);
        applyStimulus(OP_LW, 1, 0, 1, S_DECODE);
        applyStimulus(OP_LW, 1, 0, 1, S_MEMADR);
        runQueue();

        // Now in MEMREAD; drop reset between clock edges.
        #1;
        checkOutput("preResetState", 32'(fsm_state), 32'(S_MEMREAD));
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("asyncResetState", 32'(fsm_state), 32'(S_IDLE));
        checkOutput("asyncResetEnables", 32'({PCWrite, IRWrite, RegWrite, MemWrite}), 32'd0);
        checkOutput("asyncResetOuts", 32'(dutOuts), 32'(specOutputs(S_IDLE, 0, 0, OP_LW)));
        @(negedge clk);

        applyStimulus(OP_LW, 0, 0, 0, S_IDLE);
        applyStimulus(OP_LW, 1, 0, 0, S_IDLE);
        applyInstr(OP_LW, 0);
        applyStimulus(OP_RTYPE, 1, 0, 0, S_FETCH);
        runQueue();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
